cheshire_eoc_reporter: RTL and testbench
========================================

Name: cheshire_eoc_reporter

Overview:
SoC-side end-of-computation (EOC) responder, the device end of the bench's exit-code polling and PC-hang detection. Software writes its exit code into a small register slave; the block latches it and presents a sticky EOC flag plus exit code to the bench and SoC status pins. A hardware watchdog monitors core-0 commit PC and declares a hang if it stays unchanged for a programmable number of cycles. Sits on the Cheshire register bus next to the SoC regs.

Parameters:
AddrWidth, 8, register byte-address width
PcWidth, 64, commit PC width
HangCyclesDefault, 10000, reset value of HANG_LIMIT
HangExitCode, 32'h0000_0DEA, exit code reported on watchdog hang

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
reg_req_valid_i  in  1  register request valid
reg_req_ready_o  out  1  request accepted this cycle
reg_req_addr_i  in  AddrWidth  byte address, word-aligned
reg_req_write_i  in  1  1=write, 0=read
reg_req_wdata_i  in  32  write data
reg_rsp_valid_o  out  1  response pulse
reg_rsp_rdata_o  out  32  read data
reg_rsp_error_o  out  1  unmapped address
commit_ack_i  in  1  core-0 commit-port-0 acknowledge
commit_pc_i  in  PcWidth  core-0 commit PC
eoc_o  out  1  sticky end-of-computation
exit_code_o  out  32  exit code, valid when eoc_o=1
hang_o  out  1  sticky watchdog hang

Behaviour:
- Reset (async, rst_i=1): state IDLE; eoc_o=0, hang_o=0, exit_code_o=0, reg_rsp_valid_o=0, reg_rsp_rdata_o=0, reg_rsp_error_o=0, reg_req_ready_o=0; HANG_LIMIT=HangCyclesDefault; counter, last PC, captured PC = 0. Reset mid-operation aborts any pending response with no pulse.
- Handshake: at most one outstanding request. reg_req_ready_o = !rsp_pending, outside reset. Accept when valid&&ready. Response one cycle after accept as a single-cycle reg_rsp_valid_o pulse with no backpressure. Back-to-back throughput is therefore one request per 2 cycles.
- Register map (32-bit words):
  - 0x00 EXIT: W: if wdata[0]=1 and state is IDLE/ARMED, then exit_code_o<=wdata[31:1] (zero-extended), eoc_o<=1, state DONE. wdata[0]=0 is ignored. R: {exit_code[30:0], eoc}.
  - 0x04 STATUS: RO = {29'b0, hang, eoc, armed}. Writes are ignored, no error.
  - 0x08 HANG_LIMIT: RW 32-bit. 0 disables the watchdog.
  - 0x0C HANG_PC_LO and 0x10 HANG_PC_HI: see optional feature.
  - Any other address: error=1, rdata=0, no side effect.
- FSM:
  - IDLE -> ARMED on the first commit_ack_i=1; last_pc<=commit_pc_i, cnt<=0.
  - ARMED, each cycle: if commit_pc_i==last_pc, cnt<=cnt+1 (saturating at 2^32-1); else last_pc<=commit_pc_i and cnt<=0.
  - ARMED -> HUNG when HANG_LIMIT!=0 and cnt+1 reaches HANG_LIMIT on a same-PC cycle: hang_o<=1, eoc_o<=1, exit_code_o<=HangExitCode.
  - ARMED -> DONE on an EXIT write with bit0=1.
  - IDLE -> DONE is also allowed (EXIT write before any commit).
  - DONE and HUNG are terminal until reset. Further EXIT writes are acknowledged without error but do not change outputs.
- Simultaneous events:
  - Accepted EXIT write in the same cycle as hang detection: software wins; DONE, hang_o stays 0.
  - A HANG_LIMIT write takes effect the next cycle. If it is lowered to a value <= current cnt, hang fires on the next same-PC cycle.
- Outputs are registered; eoc_o rises 1 cycle after EXIT write acceptance.

Optional Feature:
CHESHIRE_EOC_HANG_PC_EN
- Defined: on the ARMED->HUNG transition, last_pc is captured. 0x0C reads captured[31:0]; 0x10 reads captured[PcWidth-1:32], zero-padded. Both are RO and read 0 before any hang.
- Undefined: no capture register; 0x0C and 0x10 decode as unmapped (error=1, rdata=0).

Test Plan:
- Reset, read 0x04 -> rdata=0, error=0. Read 0x08 -> 10000. Read 0x14 -> error=1.
- commit_ack with PCs 0x8000_0000, 0x8000_0004, ...; write 0x00 = 0x0000_0001 -> eoc_o=1 next cycle, exit_code_o=0, STATUS=0b011.
- Write 0x00 = 0x0000_0055 -> exit_code_o=0x2A. A later write of 0x0000_0003 leaves exit_code_o=0x2A.
- HANG_LIMIT=16, commit PC held at 0x8000_0100 -> hang_o=eoc_o=1 exactly 16 same-PC cycles after arming, exit_code_o=0xDEA. With the macro defined, 0x0C=0x8000_0100 and 0x10=0.
- HANG_LIMIT=0 with PC held for 20000 cycles -> no hang. HANG_LIMIT=4 with EXIT(bit0=1) accepted on the detection cycle -> DONE, hang_o=0.
- Assert rst_i mid-request (valid held) -> no rsp pulse; all outputs 0 asynchronously; HANG_LIMIT back to 10000.

Source files
------------

// File: rtl/cheshire_eoc_reporter.sv
// End-of-computation responder: latches software exit code, runs a commit-PC watchdog.
// Latency: register response one cycle after accept; eoc_o/hang_o registered (1 cycle).
// Backpressure: one outstanding request; ready drops while a response is in flight (1 req / 2 cycles).
// Optional: define CHESHIRE_EOC_HANG_PC_EN to capture the hung PC at 0x0C/0x10.
module cheshire_eoc_reporter #(
    parameter int unsigned AddrWidth         = 8,
    parameter int unsigned PcWidth           = 64,
    parameter int unsigned HangCyclesDefault = 10000,
    parameter logic [31:0] HangExitCode      = 32'h0000_0DEA
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 reg_req_valid_i,
    output logic                 reg_req_ready_o,
    input  logic [AddrWidth-1:0] reg_req_addr_i,
    input  logic                 reg_req_write_i,
    input  logic [31:0]          reg_req_wdata_i,
    output logic                 reg_rsp_valid_o,
    output logic [31:0]          reg_rsp_rdata_o,
    output logic                 reg_rsp_error_o,
    input  logic                 commit_ack_i,
    input  logic [PcWidth-1:0]   commit_pc_i,
    output logic                 eoc_o,
    output logic [31:0]          exit_code_o,
    output logic                 hang_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2,
        HUNG  = 2'd3
    } state_t;

    localparam logic [AddrWidth-1:0] ADDR_EXIT     = AddrWidth'(8'h00);
    localparam logic [AddrWidth-1:0] ADDR_STATUS   = AddrWidth'(8'h04);
    localparam logic [AddrWidth-1:0] ADDR_LIMIT    = AddrWidth'(8'h08);
`ifdef CHESHIRE_EOC_HANG_PC_EN
    localparam logic [AddrWidth-1:0] ADDR_HANG_LO  = AddrWidth'(8'h0C);
    localparam logic [AddrWidth-1:0] ADDR_HANG_HI  = AddrWidth'(8'h10);
`endif

    state_t               state;
    logic                 armed;
    logic [31:0]          hang_limit;
    logic [31:0]          cnt;
    logic [PcWidth-1:0]   last_pc;
`ifdef CHESHIRE_EOC_HANG_PC_EN
    logic [PcWidth-1:0]   captured_pc;
    logic [63:0]          captured_ext;
`endif

    logic        accept;
    logic        exit_wr;
    logic        same_pc;
    logic [32:0] cnt_inc;
    logic        hang_hit;
    logic [31:0] rd_dat;
    logic        rd_err;

    // The response register doubles as the outstanding-request flag; reset forces ready low.
    assign reg_req_ready_o = ~rst_i & ~reg_rsp_valid_o;
    assign accept          = reg_req_valid_i & reg_req_ready_o;

    // Only IDLE/ARMED react to an EXIT write; terminal states just acknowledge it.
    assign exit_wr = accept & reg_req_write_i & (reg_req_addr_i == ADDR_EXIT)
                   & reg_req_wdata_i[0] & ((state == IDLE) | (state == ARMED));

    // Compare with >= so a limit lowered below the running count fires on the next same-PC cycle.
    assign same_pc  = (commit_pc_i == last_pc);
    assign cnt_inc  = {1'b0, cnt} + 33'd1;
    assign hang_hit = (state == ARMED) & (hang_limit != 32'd0) & same_pc
                    & (cnt_inc >= {1'b0, hang_limit});

`ifdef CHESHIRE_EOC_HANG_PC_EN
    // Zero-pad the captured PC to 64 bits so the HI word is well defined for narrow PCs.
    always_comb begin
        captured_ext                = '0;
        captured_ext[PcWidth-1:0]   = captured_pc;
    end
`endif

    // Read decode from current register values; unmapped addresses return 0 with error.
    always_comb begin
        rd_dat = 32'd0;
        rd_err = 1'b0;
        case (reg_req_addr_i)
            ADDR_EXIT:    rd_dat = {exit_code_o[30:0], eoc_o};
            ADDR_STATUS:  rd_dat = {29'd0, hang_o, eoc_o, armed};
            ADDR_LIMIT:   rd_dat = hang_limit;
`ifdef CHESHIRE_EOC_HANG_PC_EN
            ADDR_HANG_LO: rd_dat = captured_ext[31:0];
            ADDR_HANG_HI: rd_dat = captured_ext[63:32];
`endif
            default:      rd_err = 1'b1;
        endcase
    end

    // Bus side: single-cycle response pulse and the HANG_LIMIT register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_rsp_valid_o <= 1'b0;
            reg_rsp_rdata_o <= 32'd0;
            reg_rsp_error_o <= 1'b0;
            hang_limit      <= HangCyclesDefault;
        end else begin
            reg_rsp_valid_o <= accept;
            reg_rsp_rdata_o <= (accept && !reg_req_write_i) ? rd_dat : 32'd0;
            reg_rsp_error_o <= accept & rd_err;
            if (accept && reg_req_write_i && reg_req_addr_i == ADDR_LIMIT) begin
                hang_limit <= reg_req_wdata_i;
            end
        end
    end

    // EOC / watchdog FSM; a software exit beats a hang detected in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            armed       <= 1'b0;
            eoc_o       <= 1'b0;
            hang_o      <= 1'b0;
            exit_code_o <= 32'd0;
            cnt         <= 32'd0;
            last_pc     <= '0;
`ifdef CHESHIRE_EOC_HANG_PC_EN
            captured_pc <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (exit_wr) begin
                        state       <= DONE;
                        eoc_o       <= 1'b1;
                        exit_code_o <= {1'b0, reg_req_wdata_i[31:1]};
                    end else if (commit_ack_i) begin
                        state   <= ARMED;
                        armed   <= 1'b1;
                        last_pc <= commit_pc_i;
                        cnt     <= 32'd0;
                    end
                end
                ARMED: begin
                    if (exit_wr) begin
                        state       <= DONE;
                        eoc_o       <= 1'b1;
                        exit_code_o <= {1'b0, reg_req_wdata_i[31:1]};
                    end else if (hang_hit) begin
                        state       <= HUNG;
                        eoc_o       <= 1'b1;
                        hang_o      <= 1'b1;
                        exit_code_o <= HangExitCode;
`ifdef CHESHIRE_EOC_HANG_PC_EN
                        captured_pc <= last_pc;
`endif
                    end else if (same_pc) begin
                        if (cnt != 32'hFFFF_FFFF) begin
                            cnt <= cnt_inc[31:0];
                        end
                    end else begin
                        last_pc <= commit_pc_i;
                        cnt     <= 32'd0;
                    end
                end
                default: begin
                    // DONE and HUNG hold until reset.
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cheshire_eoc_reporter.sv
// Directed bench for cheshire_eoc_reporter: register map, exit latch, watchdog, reset.
// Latency: bus driver returns on the negedge after the accept edge (response cycle).
// Backpressure: driver waits for ready before presenting the accept edge.
module tb_cheshire_eoc_reporter;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        commit_ack;
    logic [63:0] commit_pc;
    logic        eoc;
    logic [31:0] exit_code;
    logic        hang;

    int n_checks = 0;
    int n_fail   = 0;

    cheshire_eoc_reporter dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .reg_req_valid_i (req_valid),
        .reg_req_ready_o (req_ready),
        .reg_req_addr_i  (req_addr),
        .reg_req_write_i (req_write),
        .reg_req_wdata_i (req_wdata),
        .reg_rsp_valid_o (rsp_valid),
        .reg_rsp_rdata_o (rsp_rdata),
        .reg_rsp_error_o (rsp_error),
        .commit_ack_i    (commit_ack),
        .commit_pc_i     (commit_pc),
        .eoc_o           (eoc),
        .exit_code_o     (exit_code),
        .hang_o          (hang)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus driver: present request at a negedge, wait for ready, return response sampled at next negedge.
    task automatic bus_op(input logic [7:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output logic rv);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 8) begin
            $display("FAIL bus_ready_timeout addr=%h ready stayed %b, required 1", a, req_ready);
            n_fail++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rd = rsp_rdata;
        er = rsp_error;
        rv = rsp_valid;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = 1'b0;
        commit_ack = 1'b0;
        commit_pc  = 64'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic er, rv;
        #1;
        n_checks++;
        if ({eoc, hang, exit_code, rsp_valid, rsp_rdata, rsp_error, req_ready} !== 68'd0) begin
            $display("FAIL reset_outputs got eoc=%b hang=%b exit=%h rv=%b rd=%h er=%b rdy=%b, required all 0",
                     eoc, hang, exit_code, rsp_valid, rsp_rdata, rsp_error, req_ready);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        bus_op(8'h04, 1'b0, 32'd0, rd, er, rv);
        n_checks++;
        if ({rv, er, rd} !== {1'b1, 1'b0, 32'd0}) begin
            $display("FAIL reset_status got rv=%b er=%b rd=%h, required rv=1 er=0 rd=0", rv, er, rd);
            n_fail++;
        end
        n_checks++;
        if (req_ready !== 1'b0) begin
            $display("FAIL ready_during_rsp got %b, required 0", req_ready);
            n_fail++;
        end
        bus_op(8'h08, 1'b0, 32'd0, rd, er, rv);
        n_checks++;
        if ({rv, er, rd} !== {1'b1, 1'b0, 32'd10000}) begin
            $display("FAIL reset_limit got rv=%b er=%b rd=%0d, required rv=1 er=0 rd=10000", rv, er, rd);
            n_fail++;
        end
        bus_op(8'h14, 1'b0, 32'd0, rd, er, rv);
        n_checks++;
        if ({rv, er, rd} !== {1'b1, 1'b1, 32'd0}) begin
            $display("FAIL unmapped_14 got rv=%b er=%b rd=%h, required rv=1 er=1 rd=0", rv, er, rd);
            n_fail++;
        end
        bus_op(8'h0C, 1'b0, 32'd0, rd, er, rv);
        n_checks++;
`ifdef CHESHIRE_EOC_HANG_PC_EN
        if ({er, rd} !== {1'b0, 32'd0}) begin
            $display("FAIL hang_pc_lo_reset got er=%b rd=%h, required er=0 rd=0", er, rd);
            n_fail++;
        end
`else
        if ({er, rd} !== {1'b1, 32'd0}) begin
            $display("FAIL hang_pc_lo_unmapped got er=%b rd=%h, required er=1 rd=0", er, rd);
            n_fail++;
        end
`endif
    endtask

    task automatic test_exit_basic();
        logic [31:0] rd;
        logic er, rv;
        do_reset();
        commit_ack = 1'b1;
        commit_pc  = 64'h8000_0000;
        @(negedge clk);
        commit_pc  = 64'h8000_0004;
        @(negedge clk);
        commit_pc  = 64'h8000_0008;
        n_checks++;
        if (eoc !== 1'b0) begin
            $display("FAIL eoc_before_exit got %b, required 0", eoc);
            n_fail++;
        end
        bus_op(8'h00, 1'b1, 32'h0000_0001, rd, er, rv);
        n_checks++;
        if ({eoc, exit_code, er} !== {1'b1, 32'd0, 1'b0}) begin
            $display("FAIL exit_one got eoc=%b exit=%h er=%b, required eoc=1 exit=0 er=0", eoc, exit_code, er);
            n_fail++;
        end
        bus_op(8'h04, 1'b0, 32'd0, rd, er, rv);
        n_checks++;
        if (rd !== 32'd3) begin
            $display("FAIL status_done_armed got %h, required 3", rd);
            n_fail++;
        end
    endtask

    task automatic test_exit_code();
        logic [31:0] rd;
        logic er, rv;
        do_reset();
        bus_op(8'h00, 1'b1, 32'h0000_0054, rd, er, rv);
        n_checks++;
        if ({eoc, exit_code} !== {1'b0, 32'd0}) begin
            $display("FAIL exit_bit0_clear got eoc=%b exit=%h, required eoc=0 exit=0", eoc, exit_code);
            n_fail++;
        end
        bus_op(8'h00, 1'b1, 32'h0000_0055, rd, er, rv);
        n_checks++;
        if ({eoc, exit_code} !== {1'b1, 32'h2A}) begin
            $display("FAIL exit_55 got eoc=%b exit=%h, required eoc=1 exit=2a", eoc, exit_code);
            n_fail++;
        end
        bus_op(8'h00, 1'b1, 32'h0000_0003, rd, er, rv);
        n_checks++;
        if ({exit_code, er, rv} !== {32'h2A, 1'b0, 1'b1}) begin
            $display("FAIL exit_terminal got exit=%h er=%b rv=%b, required exit=2a er=0 rv=1", exit_code, er, rv);
            n_fail++;
        end
        bus_op(8'h00, 1'b0, 32'd0, rd, er, rv);
        n_checks++;
        if (rd !== 32'h55) begin
            $display("FAIL exit_readback got %h, required 55", rd);
            n_fail++;
        end
        bus_op(8'h04, 1'b0, 32'd0, rd, er, rv);
        n_checks++;
        if (rd !== 32'd2) begin
            $display("FAIL status_done_unarmed got %h, required 2", rd);
            n_fail++;
        end
    endtask

    task automatic test_hang();
        logic [31:0] rd;
        logic er, rv;
        do_reset();
        bus_op(8'h08, 1'b1, 32'd16, rd, er, rv);
        commit_ack = 1'b1;
        commit_pc  = 64'h8000_0100;
        @(posedge clk);
        repeat (15) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({hang, eoc} !== 2'b00) begin
            $display("FAIL hang_early got hang=%b eoc=%b after 15 cycles, required 0 0", hang, eoc);
            n_fail++;
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({hang, eoc, exit_code} !== {1'b1, 1'b1, 32'h0DEA}) begin
            $display("FAIL hang_fire got hang=%b eoc=%b exit=%h, required 1 1 00000dea", hang, eoc, exit_code);
            n_fail++;
        end
        bus_op(8'h04, 1'b0, 32'd0, rd, er, rv);
        n_checks++;
        if (rd !== 32'd7) begin
            $display("FAIL status_hung got %h, required 7", rd);
            n_fail++;
        end
        bus_op(8'h10, 1'b0, 32'd0, rd, er, rv);
        n_checks++;
`ifdef CHESHIRE_EOC_HANG_PC_EN
        if ({er, rd} !== {1'b0, 32'd0}) begin
            $display("FAIL hang_pc_hi got er=%b rd=%h, required er=0 rd=0", er, rd);
            n_fail++;
        end
        bus_op(8'h0C, 1'b0, 32'd0, rd, er, rv);
        n_checks++;
        if ({er, rd} !== {1'b0, 32'h8000_0100}) begin
            $display("FAIL hang_pc_lo got er=%b rd=%h, required er=0 rd=80000100", er, rd);
            n_fail++;
        end
`else
        if ({er, rd} !== {1'b1, 32'd0}) begin
            $display("FAIL hang_pc_hi_unmapped got er=%b rd=%h, required er=1 rd=0", er, rd);
            n_fail++;
        end
`endif
        bus_op(8'h00, 1'b1, 32'h0000_0011, rd, er, rv);
        n_checks++;
        if ({exit_code, hang, er} !== {32'h0DEA, 1'b1, 1'b0}) begin
            $display("FAIL hung_terminal got exit=%h hang=%b er=%b, required 00000dea 1 0", exit_code, hang, er);
            n_fail++;
        end
    endtask

    task automatic test_hang_disabled();
        logic [31:0] rd;
        logic er, rv;
        do_reset();
        bus_op(8'h08, 1'b1, 32'd0, rd, er, rv);
        commit_ack = 1'b1;
        commit_pc  = 64'h8000_0200;
        repeat (20000) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({hang, eoc} !== 2'b00) begin
            $display("FAIL hang_disabled got hang=%b eoc=%b, required 0 0", hang, eoc);
            n_fail++;
        end
        // Lower the limit far below the running count: fires on the next same-PC cycle.
        bus_op(8'h08, 1'b1, 32'd4, rd, er, rv);
        n_checks++;
        if (hang !== 1'b0) begin
            $display("FAIL limit_lower_same_cycle got hang=%b, required 0", hang);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if ({hang, exit_code} !== {1'b1, 32'h0DEA}) begin
            $display("FAIL limit_lower_fire got hang=%b exit=%h, required 1 00000dea", hang, exit_code);
            n_fail++;
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] rd;
        logic er, rv;
        do_reset();
        bus_op(8'h08, 1'b1, 32'd4, rd, er, rv);
        commit_ack = 1'b1;
        commit_pc  = 64'h8000_0300;
        // Arm on the next edge; the 4th edge after that is the detection edge.
        repeat (4) @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 8'h00;
        req_write = 1'b1;
        req_wdata = 32'h0000_0001;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if ({rsp_valid, eoc, hang, exit_code} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
            $display("FAIL sw_wins got rv=%b eoc=%b hang=%b exit=%h, required 1 1 0 0",
                     rsp_valid, eoc, hang, exit_code);
            n_fail++;
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (hang !== 1'b0) begin
            $display("FAIL sw_wins_sticky got hang=%b, required 0", hang);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        do_reset();
        pulses = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 8'h04;
        req_write = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) pulses++;
        end
        req_valid = 1'b0;
        n_checks++;
        if (pulses !== 3) begin
            $display("FAIL back_to_back got %0d responses in 6 cycles, required 3", pulses);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic er, rv;
        int pulses;
        do_reset();
        bus_op(8'h08, 1'b1, 32'd77, rd, er, rv);
        bus_op(8'h00, 1'b1, 32'h0000_0003, rd, er, rv);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 8'h08;
        req_write = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rsp_valid, req_ready, eoc, hang, exit_code, rsp_rdata, rsp_error} !== 68'd0) begin
            $display("FAIL async_reset got rv=%b rdy=%b eoc=%b hang=%b exit=%h rd=%h er=%b, required all 0",
                     rsp_valid, req_ready, eoc, hang, exit_code, rsp_rdata, rsp_error);
            n_fail++;
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            $display("FAIL reset_no_pulse got %0d pulses, required 0", pulses);
            n_fail++;
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        bus_op(8'h08, 1'b0, 32'd0, rd, er, rv);
        n_checks++;
        if (rd !== 32'd10000) begin
            $display("FAIL reset_limit_restore got %0d, required 10000", rd);
            n_fail++;
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 8'h00;
        req_write  = 1'b0;
        req_wdata  = 32'd0;
        commit_ack = 1'b0;
        commit_pc  = 64'd0;
        test_reset();
        test_exit_basic();
        test_exit_code();
        test_hang();
        test_hang_disabled();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
